slip_msg_receiver: RTL and testbench

//  SLIP-decodes a byte stream (from a uart_rx instance) into fixed-length message words. Receive-side

---
 rtl/slip_msg_receiver_if.sv | 38 +++
 rtl/slip_msg_receiver.sv | 172 +++++++++++++++++
 tb/tb_slip_msg_receiver.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slip_msg_receiver_if.sv
// Byte-stream input and decoded-message output bundle for slip_msg_receiver.
// The slave modport is the receiver; the master modport is the byte source
// plus the message consumer.
interface slip_msg_receiver_if #(
  parameter int MSG_BYTES     = 5,
  parameter int ERR_CNT_WIDTH = 8
);
  logic [7:0]               data;
  logic                     data_ready;
  logic [8*MSG_BYTES-1:0]   msg;
  logic                     msg_valid;
  logic                     msg_read_en;
  logic                     frame_err;
  logic                     overflow;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport slave (
    input  data,
    input  data_ready,
    input  msg_read_en,
    output msg,
    output msg_valid,
    output frame_err,
    output overflow,
    output err_count
  );

  modport master (
    output data,
    output data_ready,
    output msg_read_en,
    input  msg,
    input  msg_valid,
    input  frame_err,
    input  overflow,
    input  err_count
  );
endinterface

// File: rtl/slip_msg_receiver.sv
// SLIP decoder turning a byte stream into fixed-length messages.
// A frame is END, MSG_BYTES decoded data bytes, END. One decoded message is
// held under a valid/read handshake. Malformed frames raise frame_err; a good
// frame arriving while the holding register is still full raises overflow.
// Both events feed a saturating error counter.
module slip_msg_receiver #(
  parameter int MSG_BYTES     = 5,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  slip_msg_receiver_if.slave  bus
);

  localparam int          MSG_W = 8 * MSG_BYTES;
  localparam int          CNT_W = $clog2(MSG_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSG_BYTES);

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_DATA    = 2'd1,
    ST_ESC     = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MSG_W-1:0]         asm_q, asm_d;
  logic [MSG_W-1:0]         msg_q, msg_d;
  logic                     msg_valid_q, msg_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overflow_q, overflow_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Per-byte decode events
  logic       complete;
  logic       shift_en;
  logic [7:0] shift_byte;
  logic       load_msg;

  // Frame decoder: classifies the current byte and computes the next FSM state,
  // byte count and assembly register. Nothing moves without a byte strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    complete    = 1'b0;
    frame_err_d = 1'b0;
    shift_en    = 1'b0;
    shift_byte  = bus.data;

    if (bus.data_ready) begin
      case (state_q)
        ST_HUNT: begin
          if (bus.data == SLIP_END) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end

        ST_DATA: begin
          if (bus.data == SLIP_END) begin
            // An empty frame (back-to-back END) is just idle line.
            if (cnt_q == CNT_FULL) begin
              complete = 1'b1;
            end else if (cnt_q != '0) begin
              frame_err_d = 1'b1;
            end
            cnt_d = '0;
          end else if (bus.data == SLIP_ESC) begin
            state_d = ST_ESC;
          end else begin
            shift_en = 1'b1;
          end
        end

        ST_ESC: begin
          if (bus.data == SLIP_ESC_END || bus.data == SLIP_ESC_ESC) begin
            shift_en   = 1'b1;
            shift_byte = (bus.data == SLIP_ESC_END) ? SLIP_END : SLIP_ESC;
            state_d    = ST_DATA;
          end else if (bus.data == SLIP_END) begin
            // The END still closes the frame, so the next frame is not lost.
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_DATA;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_DISCARD;
          end
        end

        ST_DISCARD: begin
          // Error already reported when entering here; END only resyncs.
          if (bus.data == SLIP_END) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = ST_HUNT;
          cnt_d   = '0;
        end
      endcase

      // A data byte past the message length makes the frame too long.
      if (shift_en) begin
        if (cnt_q == CNT_FULL) begin
          frame_err_d = 1'b1;
          state_d     = ST_DISCARD;
        end else begin
          asm_d = {asm_q[MSG_W-9:0], shift_byte};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Holding register, handshake and error accounting. A read in the same
  // cycle as a completion frees the slot, so the new message is accepted.
  always_comb begin
    load_msg    = complete && (!msg_valid_q || bus.msg_read_en);
    overflow_d  = complete && msg_valid_q && !bus.msg_read_en;
    msg_d       = load_msg ? asm_d : msg_q;
    msg_valid_d = msg_valid_q;
    if (load_msg) begin
      msg_valid_d = 1'b1;
    end else if (bus.msg_read_en) begin
      msg_valid_d = 1'b0;
    end
    err_cnt_d = err_cnt_q;
    if ((frame_err_d || overflow_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      asm_q       <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.msg       = msg_q;
  assign bus.msg_valid = msg_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_slip_msg_receiver.sv
// Directed bench for slip_msg_receiver. Stimulus pushes expected events into
// a queue; a monitor on the falling edge pops and compares whenever the DUT
// presents a new message, a frame_err pulse or an overflow pulse.
// A second instance with a 2-bit error counter receives identical stimulus
// to exercise saturation.
module tb_slip_msg_receiver;

  localparam int K_MSG  = 0;
  localparam int K_FERR = 1;
  localparam int K_OVF  = 2;

  typedef struct {
    int          kind;
    logic [39:0] m;
  } exp_t;

  logic clk;
  logic rst_n;

  slip_msg_receiver_if #(.MSG_BYTES(5), .ERR_CNT_WIDTH(8)) ifa ();
  slip_msg_receiver_if #(.MSG_BYTES(5), .ERR_CNT_WIDTH(2)) ifb ();

  slip_msg_receiver #(.MSG_BYTES(5), .ERR_CNT_WIDTH(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  slip_msg_receiver #(.MSG_BYTES(5), .ERR_CNT_WIDTH(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   exp_err = 0;  // model of dut_a err_count

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic scalar comparison.
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_MSG:   return "msg";
      K_FERR:  return "frame_err";
      default: return "overflow";
    endcase
  endfunction

  // Scoreboard pop for one observed DUT event.
  task automatic expect_evt(input int kind, input logic [39:0] m);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL unexpected_%s: got %s (0x%010h), expected nothing", kname(kind), kname(kind), m);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_MSG && e.m !== m)) begin
        failed++;
        $display("FAIL event: got %s 0x%010h, expected %s 0x%010h", kname(kind), m, kname(e.kind), e.m);
      end else begin
        $display("[TB] %s ok 0x%010h", kname(kind), m);
      end
    end
  endtask

  task automatic push(input int kind, input logic [39:0] m);
    exp_t e;
    e.kind = kind;
    e.m    = m;
    exp_q.push_back(e);
    if (kind != K_MSG) exp_err++;
  endtask

  // One byte strobe to both DUTs; rd drives msg_read_en in the same cycle.
  task automatic send(input logic [7:0] b, input logic rd);
    @(posedge clk); #1;
    ifa.data = b;  ifa.data_ready = 1'b1;  ifa.msg_read_en = rd;
    ifb.data = b;  ifb.data_ready = 1'b1;  ifb.msg_read_en = rd;
    @(posedge clk); #1;
    ifa.data_ready = 1'b0;  ifa.msg_read_en = 1'b0;
    ifb.data_ready = 1'b0;  ifb.msg_read_en = 1'b0;
  endtask

  task automatic read_msg();
    @(posedge clk); #1;
    ifa.msg_read_en = 1'b1;  ifb.msg_read_en = 1'b1;
    @(posedge clk); #1;
    ifa.msg_read_en = 1'b0;  ifb.msg_read_en = 1'b0;
  endtask

  // END, five plain data bytes, END (read on the closing END if rd_last).
  task automatic send_frame(input logic [39:0] m, input logic rd_last);
    send(8'hC0, 1'b0);
    for (int i = 4; i >= 0; i--) send(m[8*i +: 8], 1'b0);
    send(8'hC0, rd_last);
  endtask

  // Monitor: detect new message, frame_err and overflow pulses.
  initial begin : monitor
    logic prev_valid;
    logic rd_pend;
    prev_valid = 1'b0;
    rd_pend    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifa.msg_valid && (!prev_valid || rd_pend)) expect_evt(K_MSG, ifa.msg);
        if (ifa.frame_err) expect_evt(K_FERR, 40'h0);
        if (ifa.overflow)  expect_evt(K_OVF, 40'h0);
      end
      prev_valid = ifa.msg_valid;
      rd_pend    = ifa.msg_read_en && ifa.msg_valid;
    end
  end

  initial begin : stim
    logic [7:0] bytes_q[$];
    rst_n = 1'b0;
    ifa.data = 8'h00;  ifa.data_ready = 1'b0;  ifa.msg_read_en = 1'b0;
    ifb.data = 8'h00;  ifb.data_ready = 1'b0;  ifb.msg_read_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_msg",       64'(ifa.msg), 64'h0);
    chk("reset_msg_valid", 64'(ifa.msg_valid), 64'h0);
    chk("reset_frame_err", 64'(ifa.frame_err), 64'h0);
    chk("reset_overflow",  64'(ifa.overflow), 64'h0);
    chk("reset_err_count", 64'(ifa.err_count), 64'h0);
    rst_n = 1'b1;

    // 1: sync and basic frame; leading 55 is dropped while hunting
    push(K_MSG, 40'h0102030405);
    send(8'h55, 1'b0);
    send_frame(40'h0102030405, 1'b0);
    @(negedge clk);
    chk("t1_msg_valid", 64'(ifa.msg_valid), 64'h1);
    chk("t1_err_count", 64'(ifa.err_count), 64'h0);
    read_msg();
    @(negedge clk);
    chk("t1_read_clears_valid", 64'(ifa.msg_valid), 64'h0);

    // 2: escapes, then empty frames
    push(K_MSG, 40'hC0DB001122);
    bytes_q = '{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h00, 8'h11, 8'h22, 8'hC0};
    foreach (bytes_q[i]) send(bytes_q[i], 1'b0);
    @(negedge clk);
    chk("t2_msg", 64'(ifa.msg), 64'hC0DB001122);
    read_msg();
    send(8'hC0, 1'b0); send(8'hC0, 1'b0); send(8'hC0, 1'b0);
    @(negedge clk);
    chk("t2_empty_err_count", 64'(ifa.err_count), 64'h0);
    chk("t2_empty_no_msg",    64'(ifa.msg_valid), 64'h0);

    // 3: short frame, then long frame
    push(K_FERR, 40'h0);
    bytes_q = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0};
    foreach (bytes_q[i]) send(bytes_q[i], 1'b0);
    @(negedge clk);
    chk("t3_short_err_count", 64'(ifa.err_count), 64'h1);
    push(K_FERR, 40'h0);
    bytes_q = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0};
    foreach (bytes_q[i]) send(bytes_q[i], 1'b0);
    @(negedge clk);
    chk("t3_long_err_count", 64'(ifa.err_count), 64'h2);
    chk("t3_long_no_msg",    64'(ifa.msg_valid), 64'h0);

    // 4: bad escape discards the frame, following good frame is decoded
    push(K_FERR, 40'h0);
    bytes_q = '{8'hC0, 8'h01, 8'hDB, 8'h7F, 8'h02, 8'h03, 8'h04, 8'h05, 8'hC0};
    foreach (bytes_q[i]) send(bytes_q[i], 1'b0);
    @(negedge clk);
    chk("t4_bad_esc_no_msg", 64'(ifa.msg_valid), 64'h0);
    push(K_MSG, 40'hAABBCCDDEE);
    send_frame(40'hAABBCCDDEE, 1'b0);
    @(negedge clk);
    chk("t4_err_count", 64'(ifa.err_count), 64'h3);
    read_msg();

    // 5: overflow keeps the old message; read on closing END accepts the new one
    push(K_MSG, 40'h1111111111);
    send_frame(40'h1111111111, 1'b0);
    push(K_OVF, 40'h0);
    send_frame(40'h2222222222, 1'b0);
    @(negedge clk);
    chk("t5_ovf_msg_kept", 64'(ifa.msg), 64'h1111111111);
    chk("t5_ovf_err_count", 64'(ifa.err_count), 64'h4);
    read_msg();
    push(K_MSG, 40'h4444444444);
    send_frame(40'h4444444444, 1'b0);
    push(K_MSG, 40'h5555555555);
    send_frame(40'h5555555555, 1'b1);
    @(negedge clk);
    chk("t5_rd_msg",       64'(ifa.msg), 64'h5555555555);
    chk("t5_rd_valid",     64'(ifa.msg_valid), 64'h1);
    chk("t5_rd_err_count", 64'(ifa.err_count), 64'h4);
    read_msg();

    // 6: saturation on the 2-bit counter, counting on the 8-bit one
    for (int n = 0; n < 5; n++) begin
      push(K_FERR, 40'h0);
      send(8'hC0, 1'b0); send(8'h01, 1'b0); send(8'hC0, 1'b0);
    end
    @(negedge clk);
    chk("t6_err_count_a",   64'(ifa.err_count), 64'(exp_err));
    chk("t6_err_count_sat", 64'(ifb.err_count), 64'h3);

    // Reset mid-frame: outputs clear at once, stale bytes ignored until END
    send(8'hC0, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_msg",       64'(ifa.msg), 64'h0);
    chk("t6_rst_valid",     64'(ifa.msg_valid), 64'h0);
    chk("t6_rst_err_count", 64'(ifa.err_count), 64'h0);
    chk("t6_rst_err_b",     64'(ifb.err_count), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
    bytes_q = '{8'h03, 8'h04, 8'h05, 8'hC0};
    foreach (bytes_q[i]) send(bytes_q[i], 1'b0);
    push(K_MSG, 40'h0A0B0C0D0E);
    for (int i = 4; i >= 0; i--) send(8'h0A + 8'(4 - i), 1'b0);
    send(8'hC0, 1'b0);
    @(negedge clk);
    chk("t6_post_rst_err_count", 64'(ifa.err_count), 64'h0);
    chk("t6_post_rst_msg",       64'(ifa.msg), 64'h0A0B0C0D0E);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
